// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: icache read port, hazard/redirect controls and the
// IF/ID latch feed, with the fetch unit on the slave side.
interface fetch_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_out;
  logic [31:0] pcp4_out;
  logic        valid_out;
  logic        flush_out;

  modport slave (
    output imemREN, imemaddr, instr_out, pcp4_out, valid_out, flush_out,
    input  ihit, imemload, stall, redirect, redirect_pc
  );

  modport master (
    input  imemREN, imemaddr, instr_out, pcp4_out, valid_out, flush_out,
    output ihit, imemload, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction fetch stage: PC, icache requests, one-entry stall buffer,
// redirect handling with outstanding-request drain, and HALT stop.
module fetch_unit (
  input  logic    CLK,
  input  logic    nRST,
  fetch_if.slave  bus
);
  localparam int unsigned W          = 32;
  localparam logic [W-1:0] RESET_PC   = 32'h0000_0000;
  localparam logic [W-1:0] ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [5:0]   HALT_OP    = 6'h3F;

  typedef enum logic [1:0] {S_RUN, S_HOLD, S_DRAIN, S_HALTED} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_pc;
  logic [W-1:0]   r_drain_addr;
  logic [W-1:0]   r_buf_instr;
  logic [W-1:0]   r_buf_pcp4;

  logic [W-1:0]   w_pcp4;
  logic [W-1:0]   w_redirect_pc;
  logic           w_fetch_halt;
  logic           w_buf_halt;
  logic           w_run_hit;

  assign w_pcp4        = r_pc + W'(4);
  assign w_redirect_pc = bus.redirect_pc & ALIGN_MASK;
  assign w_fetch_halt  = (bus.imemload[31:26] == HALT_OP);
  assign w_buf_halt    = (r_buf_instr[31:26] == HALT_OP);
  assign w_run_hit     = (r_state == S_RUN) && bus.ihit && !bus.redirect;

  // State register
  always_ff @(posedge CLK) begin
    if (!nRST) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; priority redirect > stall > ihit
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN: begin
        if (bus.redirect)  w_state_nxt = bus.ihit ? S_RUN : S_DRAIN;
        else if (bus.ihit) begin
          if (bus.stall)         w_state_nxt = S_HOLD;
          else if (w_fetch_halt) w_state_nxt = S_HALTED;
        end
      end
      S_HOLD: begin
        if (bus.redirect)    w_state_nxt = S_RUN;
        else if (!bus.stall) w_state_nxt = w_buf_halt ? S_HALTED : S_RUN;
      end
      S_DRAIN: begin
        if (bus.ihit) w_state_nxt = S_RUN;
      end
      S_HALTED: begin
        if (bus.redirect) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // PC, drain address and stall buffer
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_pc         <= RESET_PC;
      r_drain_addr <= '0;
      r_buf_instr  <= '0;
      r_buf_pcp4   <= '0;
    end else begin
      if (bus.redirect) r_pc <= w_redirect_pc;
      else if (w_run_hit) r_pc <= w_pcp4;

      // The in-flight request must stay on the bus until the icache answers
      if ((r_state == S_RUN) && bus.redirect && !bus.ihit)
        r_drain_addr <= r_pc;

      if (w_run_hit && bus.stall) begin
        r_buf_instr <= bus.imemload;
        r_buf_pcp4  <= w_pcp4;
      end
    end
  end

  // Outputs; everything quiet while reset is held
  always_comb begin
    bus.imemREN   = 1'b0;
    bus.imemaddr  = RESET_PC;
    bus.valid_out = 1'b0;
    bus.instr_out = '0;
    bus.pcp4_out  = '0;
    bus.flush_out = 1'b0;
    if (nRST) begin
      bus.imemaddr  = r_pc;
      bus.flush_out = bus.redirect;
      case (r_state)
        S_RUN: begin
          bus.imemREN = 1'b1;
          if (w_run_hit && !bus.stall) begin
            bus.valid_out = 1'b1;
            bus.instr_out = bus.imemload;
            bus.pcp4_out  = w_pcp4;
          end
        end
        S_HOLD: begin
          bus.instr_out = r_buf_instr;
          bus.pcp4_out  = r_buf_pcp4;
          bus.valid_out = !bus.stall && !bus.redirect;
        end
        S_DRAIN: begin
          bus.imemREN  = 1'b1;
          bus.imemaddr = r_drain_addr;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the pipelined MIPS core. Holds the PC, issues word reads to the instruction cache, and presents each fetched instruction and its PC+4 to the IF/ID latch together with the valid and flush strobes that latch consumes. It also absorbs hazard-unit stalls with a one-entry buffer, handles branch/jump redirects with outstanding-request draining, and stops fetching after a HALT.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  reset; synchronous, active-low.
- imemREN  out  1  instruction read request to the icache.
- imemaddr  out  32  read address; always word-aligned.
- ihit  in  1  icache read complete this cycle; imemload valid.
- imemload  in  32  instruction word from the icache.
- stall  in  1  hazard unit: IF/ID cannot accept a new instruction this cycle.
- redirect  in  1  branch/jump resolved taken; fetch from redirect_pc.
- redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0.
- instr_out  out  32  instruction to IF/ID (imemload_in).
- pcp4_out  out  32  fetched PC + 4 to IF/ID (pcp4_in).
- valid_out  out  1  IF/ID must capture instr_out/pcp4_out at the next edge (drives the latch's ihit).
- flush_out  out  1  IF/ID must load a bubble (drives the latch's flush).

## Operation
- Registers: pc[31:0], drain_addr[31:0], buf_instr[31:0], buf_pcp4[31:0], state.
- States: RUN, HOLD, DRAIN, HALTED. Reset: pc=RESET_PC, state=RUN, buffers=0.
- Priority each cycle: redirect > stall > ihit.
- HALT detect: instruction with opcode [31:26]==6'h3F.
- RUN: imemREN=1, imemaddr=pc.
  - redirect & ihit: fetched word discarded; pc<=redirect_pc; stay RUN.
  - redirect & !ihit: drain_addr<=pc; pc<=redirect_pc; go DRAIN.
  - ihit & stall: buf_instr<=imemload, buf_pcp4<=pc+4, pc<=pc+4; go HOLD.
  - ihit & !stall: valid_out=1, instr_out=imemload, pcp4_out=pc+4; pc<=pc+4; go HALTED if word is HALT, else stay.
  - !ihit: hold pc.
- HOLD: imemREN=0; instr_out=buf_instr, pcp4_out=buf_pcp4.
  - redirect: buffer dropped; pc<=redirect_pc; go RUN.
  - !stall: valid_out=1; go HALTED if buf_instr is HALT, else RUN.
  - stall: remain.
- DRAIN: imemREN=1, imemaddr=drain_addr (outstanding request held stable until it completes); valid_out=0.
  - redirect: pc<=redirect_pc (latest target wins); stay DRAIN unless ihit this cycle, then RUN.
  - ihit: word discarded; go RUN.
- HALTED: imemREN=0, valid_out=0. redirect: pc<=redirect_pc, go RUN (wrong-path halt squashed). Otherwise only reset exits.
- flush_out = redirect & nRST, in every state.
- Arithmetic: pc+4 modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0).
- Idle outputs: instr_out/pcp4_out = 0 when valid_out=0 and not in HOLD.

## Timing
- While nRST=0: imemREN=0, imemaddr=RESET_PC, valid_out=0, flush_out=0, instr_out=0, pcp4_out=0.
- First cycle after release: imemREN=1, imemaddr=RESET_PC.
- valid_out, instr_out, pcp4_out, flush_out combinational from ihit/imemload/stall/redirect and state; IF/ID samples them at the next edge.
- Throughput: one instruction per cycle while ihit=1 and stall=0.
- Redirect latency: imemaddr=redirect_pc on the cycle after redirect (RUN with ihit, HOLD, HALTED); otherwise the cycle after the drained ihit.
- Reset asserted mid-DRAIN/HOLD: all state cleared at that edge; drained/buffered word lost.

## Test plan
- Reset, ihit=1, imemload=8C010000, stall=0 -> imemaddr 0,4,8; pcp4_out 4,8,C; valid_out=1 each cycle.
- ihit with stall=1 for 3 cycles at pc=10 -> HOLD, imemREN=0, valid_out=0; stall drops -> valid_out=1, pcp4_out=14, next imemaddr=14.
- redirect=1, redirect_pc=40, ihit=0 at pc=20 -> flush_out=1; imemaddr stays 20 until ihit; word discarded; then imemaddr=40.
- Fetch FC000000 at pc=8 -> valid_out=1, pcp4_out=C, then imemREN=0; redirect to 100 -> imemaddr=100, fetch resumes.
- pc=FFFFFFFC, ihit -> pcp4_out=0, next imemaddr=0.
- nRST low mid-DRAIN -> next cycle imemaddr=RESET_PC, valid_out=0, state RUN.
